// File: rtl/alarm_trigger.sv
// alarm_trigger: compares the live clock time against the stored alarm time
// and drives the buzzer. A three-state controller (IDLE / RINGING / SNOOZE)
// times the ring and snooze periods in whole seconds using the 1 Hz enable.
module alarm_trigger #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tick_1hz,
    input  logic [4:0] time_hour,
    input  logic [5:0] time_min,
    input  logic [5:0] time_sec,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    input  logic [5:0] alarm_sec,
    input  logic       alarm_on,
    input  logic       setting,
    input  logic       snooze,
    input  logic       stop,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2
    } state_t;

    // Counters end one below the parameter so RING_SEC=1 rings for one tick.
    localparam logic [8:0] RING_LAST   = 9'(RING_SEC - 1);
    localparam logic [8:0] SNOOZE_LAST = 9'(SNOOZE_SEC - 1);

    state_t     r_state;
    state_t     w_nextState;
    logic [8:0] r_ringCnt;
    logic [8:0] w_nextRingCnt;
    logic [8:0] r_snoozeCnt;
    logic [8:0] w_nextSnoozeCnt;
    logic       r_buzzer;
    logic       w_nextBuzzer;
    logic       r_matchQ;
    logic       w_match;
    logic       w_isIdle;
    logic       w_trigger;
    logic       w_cancel;

    assign w_match   = (time_hour == alarm_hour) && (time_min == alarm_min) &&
                       (time_sec == alarm_sec);
    // Encoding 3 is never produced but is treated exactly like IDLE.
    assign w_isIdle  = (r_state != ST_RINGING) && (r_state != ST_SNOOZE);
    // Edge-based: an edge masked by setting or a disarmed switch is lost.
    assign w_trigger = w_match && !r_matchQ && alarm_on && !setting && w_isIdle;
    // Disarming and stop share the highest priority after reset.
    assign w_cancel  = !alarm_on || stop;

    // State register together with the counters, the buzzer and the match history.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_ringCnt   <= 9'd0;
            r_snoozeCnt <= 9'd0;
            r_buzzer    <= 1'b0;
            r_matchQ    <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_ringCnt   <= w_nextRingCnt;
            r_snoozeCnt <= w_nextSnoozeCnt;
            r_buzzer    <= w_nextBuzzer;
            r_matchQ    <= w_match;
        end
    end

    // Next-state logic: cancel beats snooze, which beats the per-second timeout.
    always_comb begin
        w_nextState     = r_state;
        w_nextRingCnt   = r_ringCnt;
        w_nextSnoozeCnt = r_snoozeCnt;
        w_nextBuzzer    = r_buzzer;
        case (r_state)
            ST_RINGING: begin
                if (w_cancel) begin
                    w_nextState  = ST_IDLE;
                    w_nextBuzzer = 1'b0;
                end else if (snooze) begin
                    w_nextState     = ST_SNOOZE;
                    w_nextSnoozeCnt = 9'd0;
                    w_nextBuzzer    = 1'b0;
                end else if (tick_1hz) begin
                    if (r_ringCnt == RING_LAST) begin
                        w_nextState  = ST_IDLE;
                        w_nextBuzzer = 1'b0;
                    end else begin
                        w_nextRingCnt = r_ringCnt + 9'd1;
                        w_nextBuzzer  = !r_buzzer;
                    end
                end
            end
            ST_SNOOZE: begin
                w_nextBuzzer = 1'b0;
                if (w_cancel) begin
                    w_nextState = ST_IDLE;
                end else if (tick_1hz) begin
                    if (r_snoozeCnt == SNOOZE_LAST) begin
                        w_nextState   = ST_RINGING;
                        w_nextRingCnt = 9'd0;
                        w_nextBuzzer  = 1'b1;
                    end else begin
                        w_nextSnoozeCnt = r_snoozeCnt + 9'd1;
                    end
                end
            end
            default: begin
                w_nextBuzzer = 1'b0;
                w_nextState  = ST_IDLE;
                if (w_trigger) begin
                    w_nextState   = ST_RINGING;
                    w_nextRingCnt = 9'd0;
                    w_nextBuzzer  = 1'b1;
                end
            end
        endcase
    end

    // Output decode: status flags come straight from the state register.
    always_comb begin
        ringing  = (r_state == ST_RINGING);
        snoozing = (r_state == ST_SNOOZE);
        state    = r_state;
        buzzer   = r_buzzer;
    end

endmodule

// File: tb/tb_alarm_trigger.sv
// tb_alarm_trigger: directed scenarios followed by a randomized soak, all
// checked every clock against a seconds-counting model of the alarm.
module tb_alarm_trigger;

    localparam int RING_SEC   = 4;
    localparam int SNOOZE_SEC = 3;

    logic       clock;
    logic       resetN;
    logic       tick;
    logic [4:0] tHour;
    logic [5:0] tMin;
    logic [5:0] tSec;
    logic [4:0] aHour;
    logic [5:0] aMin;
    logic [5:0] aSec;
    logic       alarmOn;
    logic       setting;
    logic       snooze;
    logic       stop;
    logic       buzzer;
    logic       ringing;
    logic       snoozing;
    logic [1:0] state;

    int compareCount = 0;
    int failCount    = 0;
    int cycleCount   = 0;

    // Reference model: state plus seconds elapsed in the current ring/snooze.
    int mState       = 0;
    int mRingTicks   = 0;
    int mSnoozeTicks = 0;
    bit mPrevMatch   = 0;

    alarm_trigger #(
        .RING_SEC   (RING_SEC),
        .SNOOZE_SEC (SNOOZE_SEC)
    ) dut (
        .clock      (clock),
        .reset_n    (resetN),
        .tick_1hz   (tick),
        .time_hour  (tHour),
        .time_min   (tMin),
        .time_sec   (tSec),
        .alarm_hour (aHour),
        .alarm_min  (aMin),
        .alarm_sec  (aSec),
        .alarm_on   (alarmOn),
        .setting    (setting),
        .snooze     (snooze),
        .stop       (stop),
        .buzzer     (buzzer),
        .ringing    (ringing),
        .snoozing   (snoozing),
        .state      (state)
    );

    // Free-running 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        compareCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock with the inputs currently applied.
    task automatic modelStep();
        bit matchNow;
        matchNow = (tHour == aHour) && (tMin == aMin) && (tSec == aSec);
        if (!resetN) begin
            mState       = 0;
            mRingTicks   = 0;
            mSnoozeTicks = 0;
            mPrevMatch   = 0;
        end else begin
            case (mState)
                0: if (matchNow && !mPrevMatch && alarmOn && !setting) begin
                       mState     = 1;
                       mRingTicks = 0;
                   end
                1: if (!alarmOn || stop) mState = 0;
                   else if (snooze) begin
                       mState       = 2;
                       mSnoozeTicks = 0;
                   end else if (tick) begin
                       mRingTicks++;
                       if (mRingTicks == RING_SEC) mState = 0;
                   end
                default: if (!alarmOn || stop) mState = 0;
                   else if (tick) begin
                       mSnoozeTicks++;
                       if (mSnoozeTicks == SNOOZE_SEC) begin
                           mState     = 1;
                           mRingTicks = 0;
                       end
                   end
            endcase
            mPrevMatch = matchNow;
        end
    endtask

    // One clock: tick every 10th cycle, model update, compare, clear pulses.
    task automatic applyStimulus();
        logic [8:0] expBuzz;
        tick = (cycleCount % 10 == 9);
        modelStep();
        @(posedge clock);
        #1;
        cycleCount++;
        expBuzz = ((mState == 1) && (mRingTicks % 2 == 0)) ? 9'd1 : 9'd0;
        checkOutput("state", 9'(state), 9'(mState));
        checkOutput("buzzer", 9'(buzzer), expBuzz);
        checkOutput("ringing", 9'(ringing), (mState == 1) ? 9'd1 : 9'd0);
        checkOutput("snoozing", 9'(snoozing), (mState == 2) ? 9'd1 : 9'd0);
        snooze = 1'b0;
        stop   = 1'b0;
        tick   = 1'b0;
    endtask

    task automatic setTime(input int h, input int m, input int s);
        tHour = 5'(h);
        tMin  = 6'(m);
        tSec  = 6'(s);
    endtask

    // Step the time onto the alarm (07:30:15) and expect ringing one clock later.
    task automatic fireAlarm(input string tag);
        setTime(7, 30, 14);
        applyStimulus();
        setTime(7, 30, 15);
        applyStimulus();
        checkOutput({tag, "_state"}, 9'(state), 9'd1);
        checkOutput({tag, "_buzzer"}, 9'(buzzer), 9'd1);
        setTime(7, 30, 16);
    endtask

    initial begin
        resetN  = 1'b0;
        tick    = 1'b0;
        alarmOn = 1'b0;
        setting = 1'b0;
        snooze  = 1'b0;
        stop    = 1'b0;
        aHour   = 5'd7;
        aMin    = 6'd30;
        aSec    = 6'd15;
        setTime(0, 0, 0);

        repeat (2) applyStimulus();
        checkOutput("reset_state", 9'(state), 9'd0);
        checkOutput("reset_buzzer", 9'(buzzer), 9'd0);
        resetN  = 1'b1;
        alarmOn = 1'b1;

        // Match edge rings; holding the matching time must not retrigger.
        setTime(7, 30, 14);
        repeat (3) applyStimulus();
        setTime(7, 30, 15);
        applyStimulus();
        checkOutput("match_state", 9'(state), 9'd1);
        checkOutput("match_buzzer", 9'(buzzer), 9'd1);
        repeat (10) applyStimulus();
        setTime(7, 30, 16);
        repeat (41) applyStimulus();
        checkOutput("timeout_state", 9'(state), 9'd0);

        // Snooze, then automatic re-ring and a full ring period.
        fireAlarm("snz_fire");
        repeat (2) applyStimulus();
        snooze = 1'b1;
        applyStimulus();
        checkOutput("snooze_state", 9'(state), 9'd2);
        checkOutput("snooze_buzzer", 9'(buzzer), 9'd0);
        repeat (31) applyStimulus();
        checkOutput("rering_state", 9'(state), 9'd1);
        repeat (41) applyStimulus();
        checkOutput("rering_end", 9'(state), 9'd0);

        // Stop and snooze together resolve to IDLE.
        fireAlarm("both_fire");
        stop   = 1'b1;
        snooze = 1'b1;
        applyStimulus();
        checkOutput("both_state", 9'(state), 9'd0);
        checkOutput("both_buzzer", 9'(buzzer), 9'd0);

        // Disarming during snooze returns to IDLE.
        fireAlarm("disarm_fire");
        snooze = 1'b1;
        applyStimulus();
        repeat (2) applyStimulus();
        alarmOn = 1'b0;
        applyStimulus();
        checkOutput("disarm_state", 9'(state), 9'd0);
        alarmOn = 1'b1;
        applyStimulus();

        // Match edge while setting is lost.
        setTime(7, 30, 14);
        applyStimulus();
        setting = 1'b1;
        setTime(7, 30, 15);
        repeat (3) applyStimulus();
        setting = 1'b0;
        repeat (3) applyStimulus();
        checkOutput("setting_state", 9'(state), 9'd0);

        // Match edge while disarmed is lost, even after re-arming.
        setTime(7, 30, 14);
        alarmOn = 1'b0;
        applyStimulus();
        setTime(7, 30, 15);
        repeat (3) applyStimulus();
        alarmOn = 1'b1;
        repeat (3) applyStimulus();
        checkOutput("rearm_state", 9'(state), 9'd0);
        checkOutput("rearm_buzzer", 9'(buzzer), 9'd0);

        // Reset in the middle of a ring.
        fireAlarm("rst_ring_fire");
        applyStimulus();
        resetN = 1'b0;
        applyStimulus();
        checkOutput("rst_ring_state", 9'(state), 9'd0);
        checkOutput("rst_ring_buzzer", 9'(buzzer), 9'd0);
        checkOutput("rst_ring_ringing", 9'(ringing), 9'd0);
        resetN = 1'b1;
        applyStimulus();

        // Reset in the middle of a snooze, then a normal ring.
        fireAlarm("rst_snz_fire");
        snooze = 1'b1;
        applyStimulus();
        resetN = 1'b0;
        applyStimulus();
        checkOutput("rst_snz_state", 9'(state), 9'd0);
        checkOutput("rst_snz_snoozing", 9'(snoozing), 9'd0);
        resetN = 1'b1;
        applyStimulus();
        fireAlarm("post_reset_fire");

        // Randomized soak around the alarm time.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) setTime(7, 30, 15);
            else setTime(7, 30, int'($urandom_range(0, 59)));
            snooze = ($urandom_range(0, 19) == 0);
            stop   = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 79) == 0) alarmOn = ~alarmOn;
            if ($urandom_range(0, 99) == 0) setting = ~setting;
            resetN = ($urandom_range(0, 299) != 0);
            applyStimulus();
        end
        resetN = 1'b1;
        applyStimulus();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/alarm_trigger.md
Name: alarm_trigger

Overview:
- Consumer side of the alarm-time setting counters: compares live clock time (hour/min/sec) against the stored alarm time and drives the buzzer.
- Sits between the timekeeping counters, the alarm-setting counters and the buzzer/LED outputs.
- Contains a 3-state FSM (IDLE, RINGING, SNOOZE) with per-second ring-timeout and snooze counters, all advanced by the 1 Hz enable.

Parameters:
- RING_SEC, 60, seconds a ring lasts before auto-stop (1..511)
- SNOOZE_SEC, 300, seconds spent in SNOOZE before re-ringing (1..511)

Ports:
- clock  in  1  system clock; all logic on posedge
- reset_n  in  1  synchronous, active-low reset
- tick_1hz  in  1  one-clock-wide pulse once per second
- time_hour  in  5  live hour, 0..23
- time_min  in  6  live minute, 0..59
- time_sec  in  6  live second, 0..59
- alarm_hour  in  5  alarm hour, 0..23
- alarm_min  in  6  alarm minute, 0..59
- alarm_sec  in  6  alarm second, 0..59
- alarm_on  in  1  arm switch (level)
- setting  in  1  high while alarm time is being edited (level)
- snooze  in  1  snooze request, single-cycle pulse
- stop  in  1  stop request, single-cycle pulse
- buzzer  out  1  buzzer drive; beeps 1 s on / 1 s off
- ringing  out  1  high in RINGING
- snoozing  out  1  high in SNOOZE
- state  out  2  0=IDLE, 1=RINGING, 2=SNOOZE (3 unused; treated as IDLE)

Behaviour:
- Reset (reset_n low at a posedge): state=IDLE, ring_cnt=0, snooze_cnt=0, match_q=0, buzzer=0, ringing=0, snoozing=0. Reset wins over every other input, including mid-ring and mid-snooze.
- match: combinational, high when time_hour==alarm_hour, time_min==alarm_min and time_sec==alarm_sec.
- match_q: registered copy of match, updated every clock.
- Trigger: asserts when match && !match_q && alarm_on && !setting && state==IDLE. It is edge-based, so a match held for a full second fires once only. An edge that occurs while setting=1 or alarm_on=0 is lost and does not fire later.
- Transition priority, evaluated each clock: reset, then !alarm_on, then stop, then snooze, then tick timeout.
- IDLE:
  - Trigger -> RINGING next clock, with ring_cnt=0 and buzzer=1.
- RINGING:
  - alarm_on=0 or stop=1 -> IDLE next clock; buzzer=0.
  - Otherwise snooze=1 -> SNOOZE; snooze_cnt=0, buzzer=0.
  - Otherwise on tick_1hz: if ring_cnt==RING_SEC-1 -> IDLE with buzzer=0; else ring_cnt+1 and buzzer toggles.
- SNOOZE:
  - alarm_on=0 or stop=1 -> IDLE.
  - snooze pulse is ignored.
  - On tick_1hz: if snooze_cnt==SNOOZE_SEC-1 -> RINGING with ring_cnt=0 and buzzer=1; else snooze_cnt+1.
  - A new time match is ignored because the trigger requires IDLE.
- stop or snooze in IDLE: no effect.
- Latency: buzzer rises 1 clock after the match edge, and falls 1 clock after stop/snooze/timeout.
- Simultaneous events:
  - stop+snooze in the same cycle resolves to IDLE.
  - tick on the same cycle as stop/snooze is ignored; the counter does not advance.
  - setting rising during RINGING has no effect; only the trigger is masked.
- Counters: 9-bit unsigned with no wrap in normal operation. Compare with == against the parameter minus 1, so RING_SEC=1 rings exactly one tick.
- Outputs are registered, except ringing, snoozing and state, which decode the state register directly.

Test Plan (bench uses RING_SEC=4, SNOOZE_SEC=3, tick every 10 clocks):
- Alarm 07:30:15, alarm_on=1, time steps 07:30:14 -> 07:30:15: state=1 and buzzer=1 one clock after the match. Time holds 07:30:15 for 10 clocks: no retrigger.
- Ringing with no input: buzzer follows 1,0,1,0 across ticks, and state returns to 0 on the 4th tick (ring_cnt==3).
- snooze pulse during RINGING: state=2, buzzer=0. After 3 ticks: state=1, buzzer=1, ring_cnt restarted (full 4 ticks again).
- stop and snooze in the same cycle during RINGING: state=0 next clock. alarm_on dropped during SNOOZE: state=0.
- setting=1 while time passes the alarm: no ring. alarm_on=0 at the match: no ring. Re-arming afterwards with time still equal does not fire.
- reset_n low for 1 clock during RINGING and during SNOOZE: all outputs 0, state=0 on that edge. The next match edge rings normally.
